// File: rtl/garbage_row_injector.sv
// Pushes penalty rows into the stacked board from the bottom, with an LFSR-chosen hole column.
// Optional GARBAGE_SAME_HOLE_EN: one hole column per continuous burst instead of per row.
`ifndef BOARD_WIDTH_BLK
`define BOARD_WIDTH_BLK 10
`endif
`ifndef BOARD_HEIGHT_BLK
`define BOARD_HEIGHT_BLK 20
`endif

module garbage_row_injector #(
  parameter int unsigned BOARD_W     = `BOARD_WIDTH_BLK,
  parameter int unsigned BOARD_H     = `BOARD_HEIGHT_BLK,
  parameter int unsigned MAX_PENDING = 15,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BOARD_W*BOARD_H-1:0] stacked_block,
  input  logic                       add_req,
  input  logic [2:0]                 add_count,
  output logic                       add_ack,
  input  logic                       insert_en,
  output logic [BOARD_W*BOARD_H-1:0] stacked_block_next,
  output logic                       board_we,
  output logic [3:0]                 pending,
  output logic                       busy,
  output logic                       top_out
);

  localparam int unsigned BOARD_N = BOARD_W * BOARD_H;
  localparam int unsigned HOLE_W  = $clog2(BOARD_W);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_SLOT = 2'd1;
  localparam logic [1:0] INSERT    = 2'd2;
  localparam logic [1:0] SETTLE    = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              enter_insert;
  logic              hole_load;
  logic              enq;
  logic              row0_filled;
  logic [4:0]        pend_sum;
  logic [3:0]        pend_sat;
  logic [7:0]        lfsr;
  logic [HOLE_W-1:0] hole_q;
  logic [HOLE_W-1:0] hole_new;

  assign enq         = add_req & ~add_ack & ~top_out;
  assign row0_filled = (stacked_block[BOARD_W-1:0] != '0);
  assign hole_new    = HOLE_W'(32'(lfsr) % BOARD_W);

  // Enqueue and insert decrement can land in the same cycle; saturate the combined result.
  always_comb begin
    pend_sum = 5'(pending) + (enq ? 5'(add_count) : 5'd0) - ((state == INSERT) ? 5'd1 : 5'd0);
    pend_sat = (pend_sum > 5'(MAX_PENDING)) ? 4'(MAX_PENDING) : pend_sum[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    enter_insert = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0 && !top_out) state_next = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (insert_en) begin
          state_next   = INSERT;
          enter_insert = 1'b1;
        end
      end
      INSERT: begin
        state_next = SETTLE;
      end
      SETTLE: begin
        if (top_out) begin
          state_next = IDLE;
        end else if (pending != '0 && insert_en) begin
          state_next   = INSERT;
          enter_insert = 1'b1;
        end else if (pending != '0) begin
          state_next = WAIT_SLOT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef GARBAGE_SAME_HOLE_EN
  logic fresh_q;

  // Armed in IDLE, consumed by the first insert of a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                fresh_q <= 1'b1;
    else if (state == IDLE)    fresh_q <= 1'b1;
    else if (enter_insert)     fresh_q <= 1'b0;
  end

  assign hole_load = enter_insert & fresh_q;
`else
  assign hole_load = enter_insert;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      hole_q   <= '0;
      add_ack  <= 1'b0;
      board_we <= 1'b0;
      pending  <= '0;
      busy     <= 1'b0;
      top_out  <= 1'b0;
    end else begin
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      add_ack  <= enq;
      board_we <= (state_next == INSERT);
      busy     <= (state_next != IDLE);
      if (hole_load) hole_q <= hole_new;
      if (state == INSERT && row0_filled) top_out <= 1'b1;
      if (state == SETTLE && top_out) pending <= '0;
      else                            pending <= pend_sat;
    end
  end

  // Shift every row up by one and fill the bottom row except the hole column.
  always_comb begin
    stacked_block_next = stacked_block;
    if (board_we) begin
      stacked_block_next[BOARD_N-BOARD_W-1:0] = stacked_block[BOARD_N-1:BOARD_W];
      stacked_block_next[BOARD_N-1 -: BOARD_W] = ~(BOARD_W'(1) << hole_q);
    end
  end

endmodule

// File: tb/tb_garbage_row_injector.sv
// Scoreboard bench for garbage_row_injector: stimulus queues expected inserts, a monitor checks each write.
// Honours GARBAGE_SAME_HOLE_EN to select the expected hole policy.
module tb_garbage_row_injector;

  localparam int unsigned W = 10;
  localparam int unsigned H = 20;
  localparam int unsigned N = W * H;

  typedef struct packed {
    logic [3:0] pend;
    logic       top;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] board;
  logic [N-1:0] next_board;
  logic         add_req;
  logic [2:0]   add_count;
  logic         add_ack;
  logic         insert_en;
  logic         board_we;
  logic [3:0]   pending;
  logic         busy;
  logic         top_out;
  logic         load;
  logic [N-1:0] load_val;
  logic [7:0]   ref_lfsr;
  logic [7:0]   lfsr_prev;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   we_last = 0;
  int   we_prev = 0;
  exp_t exp_q[$];

  garbage_row_injector dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stacked_block      (board),
    .add_req            (add_req),
    .add_count          (add_count),
    .add_ack            (add_ack),
    .insert_en          (insert_en),
    .stacked_block_next (next_board),
    .board_we           (board_we),
    .pending            (pending),
    .busy               (busy),
    .top_out            (top_out)
  );

  always #5 clk = ~clk;

  // Board register owned by the surrounding game; the bench can preload it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (board_we)  board <= next_board;
    else if (load) board <= load_val;
  end

  // Reference Fibonacci LFSR, taps 8,6,5,4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_lfsr  <= 8'hA5;
      lfsr_prev <= 8'hA5;
    end else begin
      lfsr_prev <= ref_lfsr;
      ref_lfsr  <= {ref_lfsr[6:0], ^(ref_lfsr & 8'hB8)};
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write is checked against a shift model and popped from the scoreboard.
  logic       chk_after = 1'b0;
  logic       burst_open = 1'b0;
  logic [3:0] burst_hole = '0;
  exp_t       cur;
  always @(negedge clk) begin
    logic [3:0]   hole;
    logic [W-1:0] bottom;
    logic [N-1:0] expb;
    if (!rst_n) begin
      chk_after  = 1'b0;
      burst_open = 1'b0;
    end else begin
      if (chk_after) begin
        check("pending_after_insert", 4'(pending), 4'(cur.pend));
        check("top_out_after_insert", top_out, cur.top);
        chk_after = 1'b0;
      end
      if (board_we) begin
`ifdef GARBAGE_SAME_HOLE_EN
        hole = burst_open ? burst_hole : 4'(lfsr_prev % 8'd10);
`else
        hole = 4'(lfsr_prev % 8'd10);
`endif
        bottom = ~(10'd1 << hole);
        expb   = {bottom, board[N-1:W]};
        check("board_next", next_board, expb);
        check("bottom_ones", $countones(next_board[N-1 -: W]), 9);
        burst_open = 1'b1;
        burst_hole = hole;
        we_prev    = we_last;
        we_last    = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got board_we=1 expected no write (t=%0t)", $time);
        end else begin
          cur       = exp_q.pop_front();
          chk_after = 1'b1;
        end
      end else begin
        check("passthrough", next_board, board);
        if (!busy) burst_open = 1'b0;
      end
    end
  end

  function automatic logic [N-1:0] make_board(input int s);
    logic [N-1:0] b;
    b = '0;
    for (int r = 10; r < H; r++) b[r*W +: W] = 10'((r * 37 + s * 13) ^ 341);
    return b;
  endfunction

  task automatic reset_dut(input logic [N-1:0] b);
    @(posedge clk); #1;
    rst_n = 1'b0; add_req = 1'b0; add_count = '0; insert_en = 1'b0;
    load = 1'b1; load_val = b;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; load = 1'b0;
  endtask

  task automatic set_board(input logic [N-1:0] b);
    @(posedge clk); #1 load = 1'b1; load_val = b;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic enqueue(input logic [2:0] n, input logic [3:0] exp_pend);
    logic got;
    got = 1'b0;
    @(posedge clk); #1 add_req = 1'b1; add_count = n;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (add_ack) begin got = 1'b1; break; end
    end
    check("add_ack_seen", got, 1'b1);
    check("pending_after_enqueue", 4'(pending), 4'(exp_pend));
    @(posedge clk); #1 add_req = 1'b0;
    @(negedge clk);
    check("add_ack_single_cycle", add_ack, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    logic [N-1:0] b;
    int           acks;
    rst_n = 1'b1; add_req = 1'b0; add_count = '0; insert_en = 1'b0; load = 1'b0; load_val = '0;

    // Reset values
    b = make_board(3);
    reset_dut(b);
    @(negedge clk);
    check("reset_add_ack", add_ack, 1'b0);
    check("reset_board_we", board_we, 1'b0);
    check("reset_pending", 4'(pending), 4'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_top_out", top_out, 1'b0);

    // Two rows with insert_en held high
    exp_q.push_back('{pend: 4'd1, top: 1'b0});
    exp_q.push_back('{pend: 4'd0, top: 1'b0});
    insert_en = 1'b1;
    enqueue(3'd2, 4'd2);
    wait_idle("two_rows_idle");
    check("two_rows_pending", 4'(pending), 4'd0);
    check("two_rows_spacing", we_last - we_prev, 2);
    check("old_row19_at_row17", board[18*W-1 -: W], b[N-1 -: W]);
    check("row18_ones", $countones(board[19*W-1 -: W]), 9);

    // Saturation and stalled slot
    insert_en = 1'b0;
    enqueue(3'd7, 4'd7);
    enqueue(3'd7, 4'd14);
    enqueue(3'd5, 4'd15);
    repeat (20) @(negedge clk);
    check("stall_busy", busy, 1'b1);
    check("stall_pending", 4'(pending), 4'd15);

    // Reset while busy aborts everything
    reset_dut(make_board(5));
    @(negedge clk);
    check("abort_pending", 4'(pending), 4'd0);
    check("abort_busy", busy, 1'b0);

    // Enqueue during an INSERT cycle: 3 + 2 - 1 = 4
    enqueue(3'd3, 4'd3);
    exp_q.push_back('{pend: 4'd4, top: 1'b0});
    @(posedge clk); #1 insert_en = 1'b1;
    @(posedge clk); #1 add_req = 1'b1; add_count = 3'd2; insert_en = 1'b0;
    @(negedge clk);
    check("ack_not_yet", add_ack, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ack_after_insert_cycle", add_ack, 1'b1);
    @(posedge clk); #1 add_req = 1'b0;

    // insert_en toggle around SETTLE: resume only when it returns high
    exp_q.push_back('{pend: 4'd3, top: 1'b0});
    @(posedge clk); #1 insert_en = 1'b1;
    @(posedge clk); #1 insert_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("gap_no_write_1", board_we, 1'b0);
    @(posedge clk); #1 insert_en = 1'b1;
    @(negedge clk);
    check("gap_no_write_2", board_we, 1'b0);
    exp_q.push_back('{pend: 4'd2, top: 1'b0});
    exp_q.push_back('{pend: 4'd1, top: 1'b0});
    exp_q.push_back('{pend: 4'd0, top: 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    check("resume_write", board_we, 1'b1);
    wait_idle("toggle_idle");
    check("toggle_pending", 4'(pending), 4'd0);

    // Four-row burst and hole policy
    insert_en = 1'b0;
    set_board(make_board(9));
    exp_q.push_back('{pend: 4'd3, top: 1'b0});
    exp_q.push_back('{pend: 4'd2, top: 1'b0});
    exp_q.push_back('{pend: 4'd1, top: 1'b0});
    exp_q.push_back('{pend: 4'd0, top: 1'b0});
    insert_en = 1'b1;
    enqueue(3'd4, 4'd4);
    wait_idle("burst_idle");
    for (int r = 16; r < 20; r++) begin
      check("burst_row_ones", $countones(board[r*W +: W]), 9);
`ifdef GARBAGE_SAME_HOLE_EN
      check("burst_same_hole", board[r*W +: W], board[N-1 -: W]);
`endif
    end

    // Top-out: row 0 occupied, one insert still written, then everything frozen
    insert_en = 1'b0;
    b = make_board(11);
    b[W-1:0] = 10'h001;
    set_board(b);
    enqueue(3'd3, 4'd3);
    exp_q.push_back('{pend: 4'd2, top: 1'b1});
    @(posedge clk); #1 insert_en = 1'b1;
    wait_idle("topout_idle");
    check("topout_flag", top_out, 1'b1);
    check("topout_pending", 4'(pending), 4'd0);
    check("topout_row19_written", $countones(board[N-1 -: W]), 9);
    acks = 0;
    @(posedge clk); #1 add_req = 1'b1; add_count = 3'd5;
    repeat (10) begin
      @(negedge clk);
      if (add_ack) acks++;
    end
    @(posedge clk); #1 add_req = 1'b0;
    check("topout_no_ack", acks, 0);
    check("topout_pending_frozen", 4'(pending), 4'd0);
    check("topout_still_set", top_out, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
